// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low abcdefg patterns for BCD 0..9, a = bit 6.
    localparam logic [6:0] DIGIT_CODES [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/segment7.sv
// BCD to active-low 7-segment decoder; codes above 9 decode to blank.
module segment7
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // NOTE: the default assignment before the lookup keeps this purely combinational (no latch).
    always_comb begin
        o_seg = SEG_BLANK;
        for (int k = 0; k < 10; k++) begin
            if (i_bcd == 4'(k)) begin
                o_seg = DIGIT_CODES[k];
            end
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller: frame-coherent display shadow, blanking guard
// between digits, leading-zero suppression and a single shared segment decoder.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          lz_suppress,
    output logic [6:0]                    seg_out,
    output logic                          dp_out,
    output logic [NUM_DIGITS-1:0]         an_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic                    r_run;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    scan_state_t             r_state;
    logic [4*NUM_DIGITS-1:0] r_pend_digits;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_flag;
    logic [4*NUM_DIGITS-1:0] r_disp_digits;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [NUM_DIGITS-1:0]   r_disp_sup;

    logic [CNT_W-1:0]        w_nxt_cnt;
    logic [IDX_W-1:0]        w_nxt_idx;
    scan_state_t             w_nxt_state;
    logic                    w_commit;
    logic [4*NUM_DIGITS-1:0] w_commit_digits;
    logic [NUM_DIGITS-1:0]   w_commit_dp;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic [NUM_DIGITS-1:0]   w_an_show;
    logic [3:0]              w_dec_bcd;
    logic [6:0]              w_dec_seg;

    // Outputs are registered from the next-cycle scan position, so the
    // state held in r_* always describes the cycle currently on the pins.
    always_comb begin
        w_nxt_cnt   = '0;
        w_nxt_idx   = '0;
        w_nxt_state = BLANK;
        if (r_run) begin
            w_nxt_idx = r_idx;
            if (r_cnt == CNT_LAST) begin
                w_nxt_idx = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                w_nxt_cnt = r_cnt + 1'b1;
            end
            case (r_state)
                BLANK:   w_nxt_state = (r_cnt == BLANK_END) ? SHOW : BLANK;
                SHOW:    w_nxt_state = (r_cnt == CNT_LAST) ? BLANK : SHOW;
                default: w_nxt_state = BLANK;
            endcase
        end
    end

    assign w_commit        = (w_nxt_cnt == '0) && (w_nxt_idx == '0);
    assign w_commit_digits = load ? digits_in : r_pend_digits;
    assign w_commit_dp     = load ? dp_in : r_pend_dp;

    always_comb begin
        logic w_seen_nz;
        w_lz_mask = '0;
        w_seen_nz = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (!w_seen_nz && (w_commit_digits[4*i +: 4] == 4'd0)) begin
                w_lz_mask[i] = 1'b1;
            end else begin
                w_seen_nz = 1'b1;
            end
        end
    end

    always_comb begin
        w_an_show = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_an_show[i] = (IDX_W'(i) != w_nxt_idx);
        end
    end

    // SHOW never coincides with a commit, so the display register is already settled here.
    assign w_dec_bcd = r_disp_digits[4*w_nxt_idx +: 4];

    segment7 u_segment7 (
        .i_bcd (w_dec_bcd),
        .o_seg (w_dec_seg)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run       <= 1'b0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_state     <= BLANK;
            seg_out     <= SEG_BLANK;
            dp_out      <= 1'b1;
            an_out      <= '1;
            frame_start <= 1'b0;
        end else begin
            r_run       <= 1'b1;
            r_cnt       <= w_nxt_cnt;
            r_idx       <= w_nxt_idx;
            r_state     <= w_nxt_state;
            frame_start <= w_commit;
            if (w_nxt_state == SHOW) begin
                an_out  <= w_an_show;
                seg_out <= r_disp_sup[w_nxt_idx] ? SEG_BLANK : w_dec_seg;
                dp_out  <= ~r_disp_dp[w_nxt_idx];
            end else begin
                an_out  <= '1;
                seg_out <= SEG_BLANK;
                dp_out  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_digits <= '0;
            r_pend_dp     <= '0;
            r_pend_flag   <= 1'b0;
            r_disp_digits <= '0;
            r_disp_dp     <= '0;
            r_disp_sup    <= '0;
        end else if (w_commit) begin
            if (load || r_pend_flag) begin
                r_disp_digits <= w_commit_digits;
                r_disp_dp     <= w_commit_dp;
                r_disp_sup    <= lz_suppress ? w_lz_mask : '0;
            end
            r_pend_flag <= 1'b0;
        end else if (load) begin
            r_pend_digits <= digits_in;
            r_pend_dp     <= dp_in;
            r_pend_flag   <= 1'b1;
        end
    end

    assign digit_idx = r_idx;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-level reference model queues the
// expected pins for every cycle and a negedge monitor compares them.
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int R     = 8;
    localparam int B     = 2;
    localparam int FRAME = N * R;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        lz_suppress;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic [1:0]  digit_idx;
    logic        frame_start;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .lz_suppress (lz_suppress),
        .seg_out     (seg_out),
        .dp_out      (dp_out),
        .an_out      (an_out),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic [1:0] idx;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [6:0] seg_tab [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    // Reference model state: cycle number within the run and frame-level data.
    int          c      = 0;
    bit          in_rst = 1'b1;
    logic [15:0] latest = '0;
    logic [3:0]  latest_dp = '0;
    bit          dirty  = 1'b0;
    logic [15:0] shown  = '0;
    logic [3:0]  shown_dp = '0;
    logic [3:0]  mask   = '0;
    bit          lz_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] decode(input logic [3:0] v);
        if (v > 4'd9) return 7'b1111111;
        return seg_tab[v];
    endfunction

    task automatic commit(input logic [15:0] d, input logic [3:0] dpv, input bit lzv);
        int h;
        shown    = d;
        shown_dp = dpv;
        mask     = '0;
        if (lzv) begin
            h = 0;
            for (int i = 0; i < N; i++) begin
                if (d[4*i +: 4] != 4'd0) h = i;
            end
            for (int i = h + 1; i < N; i++) mask[i] = 1'b1;
        end
    endtask

    task automatic tick(input bit r, input bit ld, input logic [15:0] d,
                        input logic [3:0] dpv, input bit lzv);
        exp_t e;
        int   slot;
        int   pos;
        rst         = r;
        load        = ld;
        digits_in   = d;
        dp_in       = dpv;
        lz_suppress = lzv;
        if (r) begin
            in_rst = 1'b1;
            latest = '0; latest_dp = '0; dirty = 1'b0;
            shown  = '0; shown_dp  = '0; mask  = '0;
            e = '{seg: 7'b1111111, dp: 1'b1, an: 4'b1111, idx: 2'd0, fs: 1'b0};
        end else begin
            c      = in_rst ? 0 : c + 1;
            in_rst = 1'b0;
            if (c % FRAME == 0) begin
                if (ld) commit(d, dpv, lzv);
                else if (dirty) commit(latest, latest_dp, lzv);
                dirty = 1'b0;
            end else if (ld) begin
                latest    = d;
                latest_dp = dpv;
                dirty     = 1'b1;
            end
            slot  = (c / R) % N;
            pos   = c % R;
            e.idx = 2'(slot);
            e.fs  = (c % FRAME == 0);
            if (pos < B) begin
                e.an  = 4'b1111;
                e.seg = 7'b1111111;
                e.dp  = 1'b1;
            end else begin
                e.an  = 4'b1111;
                e.an[slot] = 1'b0;
                e.seg = mask[slot] ? 7'b1111111 : decode(shown[4*slot +: 4]);
                e.dp  = ~shown_dp[slot];
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 16'($urandom), 4'($urandom), lz_hold);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dpv);
        tick(1'b0, 1'b1, d, dpv, lz_hold);
    endtask

    // Idle until the next tick lands on the given cycle offset within a frame.
    task automatic run_until(input int target);
        while (((c + 1) % FRAME) != target) idle(1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("seg_out", 32'(seg_out), 32'(e.seg));
            check("dp_out", 32'(dp_out), 32'(e.dp));
            check("an_out", 32'(an_out), 32'(e.an));
            check("digit_idx", 32'(digit_idx), 32'(e.idx));
            check("frame_start", 32'(frame_start), 32'(e.fs));
        end
    end

    initial begin
        rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; lz_suppress = 1'b0;
        repeat (3) tick(1'b1, 1'b0, '0, '0, 1'b0);
        idle(40);

        do_load(16'h1234, 4'b0100);
        run_until(0);
        idle(FRAME);

        lz_hold = 1'b1;
        run_until(10);
        do_load(16'h0070, 4'b0000);
        run_until(0);
        idle(FRAME);
        run_until(12);
        do_load(16'h0000, 4'b0100);
        run_until(0);
        idle(FRAME);

        lz_hold = 1'b0;
        run_until(5);
        do_load(16'hFA95, 4'b1000);
        run_until(0);
        idle(FRAME);

        run_until(3);
        do_load(16'h1111, 4'b0001);
        idle(7);
        do_load(16'h2222, 4'b0000);
        run_until(0);
        idle(FRAME);

        run_until(0);
        do_load(16'h5678, 4'b1010);
        idle(FRAME + 4);

        run_until(2 * R + 4);
        tick(1'b1, 1'b0, 16'h9999, 4'hF, 1'b0);
        tick(1'b1, 1'b1, 16'h9999, 4'hF, 1'b0);
        idle(40);

        repeat (700) begin
            tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) == 0),
                 16'($urandom), 4'($urandom), 1'($urandom));
        end
        idle(4);

        @(negedge clk);
        #1;
        check("queue_drain", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
